dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//   Data-memory responder on the CPU side of the m_data_* bus: byte address, write data and byteen in; read word out.
//   Holds the word-addressed DM array, applies byte-lane stores on the clock edge and returns load data combinationally.
//   Every accepted store is pushed into a store-log FIFO (pc, addr, merged word) drained by a valid/ready sink (bench printer/checker).
// PARAMETERS
//   DEPTH_WORDS  3072  DM size in 32-bit words; valid byte range 0 .. DEPTH_WORDS*4-1
//   ADDR_W       12    word-index width; must satisfy 2**ADDR_W >= DEPTH_WORDS
//   LOG_DEPTH    8     store-log FIFO entries; power of 2, >= 2
// PORTS
//   clk            in   1   single clock, all state updates on posedge
//   reset          in   1   synchronous, active-low: state clears on a posedge where reset==0
//   m_data_addr    in   32  byte address of M-stage access
//   m_data_wdata   in   32  store data, already lane-replicated by CPU
//   m_data_byteen  in   4   byte-lane write enables; 4'b0000 = no store
//   m_inst_addr    in   32  PC of M-stage instruction (logged with store)
//   m_data_rdata   out  32  word at m_data_addr[ADDR_W+1:2]; 0 when out of range
//   log_valid      out  1   FIFO head valid
//   log_ready      in   1   sink accepts head this cycle
//   log_pc         out  32  head: store PC
//   log_addr       out  32  head: word-aligned byte address ({addr[31:2],2'b00})
//   log_data       out  32  head: full word after byte merge
//   log_dropped    out  16  count of stores lost to full FIFO, saturates at 16'hFFFF
//   range_err      out  1   sticky: a store hit an out-of-range address
//   misalign_err   out  1   sticky: illegal byteen pattern (see CONFIGURATION)
// BEHAVIOUR
//   Reset (reset==0 at posedge): all DEPTH_WORDS words <= 0; FIFO rd/wr ptr, count <= 0; log_valid=0;
//     log_pc/log_addr/log_data=0; log_dropped=0; range_err=0; misalign_err=0. Reset wins over any same-cycle store or pop.
//   Read: combinational from array, no write-through; a store at edge N is visible on m_data_rdata after edge N.
//   In range: m_data_addr < DEPTH_WORDS*4. Out-of-range: rdata=0; store (byteen!=0) ignored, not logged, range_err<=1.
//   Store accepted when reset==1, byteen!=0, in range (and legal if DM_BYTEEN_CHECK_EN): lane i (bits 8i+7:8i) <= wdata lane i
//     where byteen[i]=1, other lanes kept. merged = resulting word, computed from pre-edge array contents.
//   Log push on every accepted store: entry {m_inst_addr, {addr[31:2],2'b00}, merged}.
//   FIFO: show-ahead; head on log_* whenever log_valid=1 (log_* content undefined-but-stable while log_valid=0: hold last).
//     pop = log_valid & log_ready. Push to empty FIFO -> log_valid=1 one cycle later (1-cycle latency).
//     count: push&!pop +1; pop&!push -1; both: unchanged (allowed when full or empty-with-no-valid: empty+push+ready pops nothing).
//     full & push & !pop: entry dropped, memory write still performed, log_dropped+1 (saturating).
//     full & push & pop: no drop. Pointers wrap mod LOG_DEPTH. ready while empty: no effect.
//   Entries leave in push order; no reordering or coalescing of stores to the same word.
//   Sticky flags clear only by reset.
// CONFIGURATION
//   DM_BYTEEN_CHECK_EN defined: legal byteen = 0001,0010,0100,1000,0011,1100,1111 only; any other nonzero
//     pattern -> store suppressed (no memory change, no log, no drop count), misalign_err<=1.
//   Undefined: any nonzero byteen accepted lane-by-lane; misalign_err tied 0 (port still present).
// TESTING
//   1 reset=0 one edge, then byteen=1111 addr=0x10 wdata=0xDEADBEEF pc=0x3000 -> next cycle rdata(0x10)=0xDEADBEEF,
//     log_valid=1, log_pc=0x3000, log_addr=0x10, log_data=0xDEADBEEF; ready=1 -> log_valid=0 next cycle.
//   2 then byteen=0100 addr=0x12 wdata=0x00AA00AA -> word 0x10 reads 0xDEAABEEF; log_addr=0x10, log_data=0xDEAABEEF.
//   3 log_ready=0, LOG_DEPTH+3 stores to distinct words -> log_dropped=3, all words written; ready=1 drains exactly
//     LOG_DEPTH entries in order, then log_valid=0.
//   4 FIFO full, same cycle store + ready=1 -> log_dropped unchanged, count stays LOG_DEPTH, newest entry at tail.
//   5 byteen=1111 addr=DEPTH_WORDS*4 (0x3000) -> no log, range_err=1, rdata=0; reset=0 mid-drain -> log_valid=0,
//     flags 0, rdata(0x10)=0 next cycle.
//   6 byteen=0110 addr=0x20 wdata=0x11223344 -> with DM_BYTEEN_CHECK_EN: word 0x20 stays 0, misalign_err=1, no log;
//     without: word 0x20=0x00223300, logged, misalign_err=0.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder on the CPU side of the m_data_* bus.
//
// Purpose
//   Holds a word-addressed data memory of DEPTH_WORDS 32-bit words. Byte-lane
//   stores are applied on the rising clock edge. Load data is returned
//   combinationally from the array, with no write-through. Every accepted store
//   is also recorded in a show-ahead store-log FIFO as {pc, word address,
//   merged word}. A valid/ready sink drains that FIFO.
//
// Optional feature
//   DM_BYTEEN_CHECK_EN : when defined, only byteen patterns 0001, 0010, 0100,
//   1000, 0011, 1100 and 1111 are legal. Any other nonzero pattern suppresses
//   the store and sets misalign_err. When undefined, any nonzero byteen is
//   accepted lane by lane and misalign_err is tied to 0.
//
// Ports
//   clk            in   1   single clock, all state updates on posedge
//   reset          in   1   synchronous, active-low
//   m_data_addr    in   32  byte address of the M-stage access
//   m_data_wdata   in   32  store data, already lane-replicated
//   m_data_byteen  in   4   byte-lane write enables, 0 = no store
//   m_inst_addr    in   32  PC of the M-stage instruction
//   m_data_rdata   out  32  addressed word, 0 when the address is out of range
//   log_valid      out  1   FIFO head valid
//   log_ready      in   1   sink accepts the head this cycle
//   log_pc         out  32  head: store PC
//   log_addr       out  32  head: word-aligned byte address
//   log_data       out  32  head: full word after the byte merge
//   log_dropped    out  16  stores lost to a full FIFO, saturating
//   range_err      out  1   sticky: a store hit an out-of-range address
//   misalign_err   out  1   sticky: illegal byteen pattern (checked build only)
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int ADDR_W      = 12,
    parameter int LOG_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_pc,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic [15:0] log_dropped,
    output logic        range_err,
    output logic        misalign_err
);

    localparam int          PTR_W      = $clog2(LOG_DEPTH);
    localparam int          CNT_W      = PTR_W + 1;
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);

`ifdef DM_BYTEEN_CHECK_EN
    function automatic logic byteen_legal(input logic [3:0] be);
        return (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) ||
               (be == 4'b1000) || (be == 4'b0011) || (be == 4'b1100) ||
               (be == 4'b1111);
    endfunction
`endif

    // Data memory and store-log storage
    logic [31:0] mem_q      [DEPTH_WORDS];
    logic [31:0] fifo_pc_q  [LOG_DEPTH];
    logic [31:0] fifo_adr_q [LOG_DEPTH];
    logic [31:0] fifo_dat_q [LOG_DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      dropped_q, dropped_d;
    logic             range_q, range_d, mis_q, mis_d;
    logic [31:0]      hold_pc_q, hold_adr_q, hold_dat_q;

    logic [ADDR_W-1:0] widx;
    logic              in_range, store_req, legal, accept;
    logic              full, pop, push_ok;
    logic [31:0]       cur_word, merged, word_addr;

    assign widx      = m_data_addr[ADDR_W+1:2];
    assign in_range  = m_data_addr < BYTE_LIMIT;
    assign store_req = |m_data_byteen;
`ifdef DM_BYTEEN_CHECK_EN
    assign legal     = byteen_legal(m_data_byteen);
`else
    assign legal     = 1'b1;
`endif
    assign accept    = store_req & in_range & legal;
    // The index is only trusted in range, so the array is never read past its end.
    assign cur_word  = in_range ? mem_q[widx] : 32'h0;
    assign word_addr = {m_data_addr[31:2], 2'b00};

    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
        end
    end

    assign m_data_rdata = cur_word;

    assign full      = cnt_q == CNT_W'(LOG_DEPTH);
    assign log_valid = cnt_q != '0;
    assign pop       = log_valid & log_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = accept & (~full | pop);

    // Show-ahead head while valid; otherwise present the last head seen.
    assign log_pc   = log_valid ? fifo_pc_q[rd_ptr_q]  : hold_pc_q;
    assign log_addr = log_valid ? fifo_adr_q[rd_ptr_q] : hold_adr_q;
    assign log_data = log_valid ? fifo_dat_q[rd_ptr_q] : hold_dat_q;

    assign log_dropped = dropped_q;
    assign range_err   = range_q;
`ifdef DM_BYTEEN_CHECK_EN
    assign misalign_err = mis_q;
`else
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        dropped_d = dropped_q;
        range_d   = range_q;
        mis_d     = mis_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push_ok) cnt_d = cnt_q - 1'b1;
        if (accept && full && !pop && dropped_q != 16'hFFFF) dropped_d = dropped_q + 1'b1;
        if (store_req && !in_range) range_d = 1'b1;
        if (store_req && !legal)    mis_d   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            dropped_q  <= '0;
            range_q    <= 1'b0;
            mis_q      <= 1'b0;
            hold_pc_q  <= '0;
            hold_adr_q <= '0;
            hold_dat_q <= '0;
        end else begin
            // A store to memory happens even when its log entry is dropped.
            if (accept) mem_q[widx] <= merged;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
            range_q   <= range_d;
            mis_q     <= mis_d;
            if (log_valid) begin
                hold_pc_q  <= fifo_pc_q[rd_ptr_q];
                hold_adr_q <= fifo_adr_q[rd_ptr_q];
                hold_dat_q <= fifo_dat_q[rd_ptr_q];
            end
        end
    end

    // Log payload storage needs no reset; cnt_q decides what is visible.
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            fifo_pc_q[wr_ptr_q]  <= m_inst_addr;
            fifo_adr_q[wr_ptr_q] <= word_addr;
            fifo_dat_q[wr_ptr_q] <= merged;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    localparam int DEPTH_WORDS = 3072;
    localparam int LOG_DEPTH   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr, m_data_wdata, m_inst_addr;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic        log_valid, log_ready;
    logic [31:0] log_pc, log_addr, log_data;
    logic [15:0] log_dropped;
    logic        range_err, misalign_err;

    dm_responder #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(12), .LOG_DEPTH(LOG_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
        .m_data_rdata(m_data_rdata),
        .log_valid(log_valid), .log_ready(log_ready),
        .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data),
        .log_dropped(log_dropped), .range_err(range_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    // Reference model: memory image, expected log order, occupancy, counters
    logic [31:0] mmem [DEPTH_WORDS];
    ent_t        sb[$];
    int          mcnt;
    int          mdrop;
    bit          mrange, mmis;
    int          n_chk, n_pass;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s actual=%h required=%h", nm, act, req);
        else n_pass++;
    endtask

    function automatic bit be_legal(input logic [3:0] be);
`ifdef DM_BYTEEN_CHECK_EN
        return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH_WORDS; i++) mmem[i] = 32'h0;
        sb.delete();
        mcnt = 0; mdrop = 0; mrange = 0; mmis = 0;
    endfunction

    // One bus cycle: drive, check visible state, let the edge happen, update the model.
    task automatic step(input logic rn, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] pc, input logic rdy);
        bit          inr, acc, popm;
        logic [31:0] w;
        reset = rn; m_data_addr = a; m_data_wdata = wd; m_data_byteen = be;
        m_inst_addr = pc; log_ready = rdy;
        #1;
        inr = a < 32'(DEPTH_WORDS * 4);
        chk("rdata", m_data_rdata, inr ? mmem[a[31:2]] : 32'h0);
        chk("log_dropped", {16'h0, log_dropped}, 32'(mdrop));
        chk("range_err", {31'h0, range_err}, {31'h0, mrange});
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, mmis});
        w = inr ? mmem[a[31:2]] : 32'h0;
        for (int l = 0; l < 4; l++) if (be[l]) w[8*l +: 8] = wd[8*l +: 8];
        acc  = (be != 0) && inr && be_legal(be);
        popm = (mcnt != 0) && rdy;
        @(posedge clk);
        #1;
        if (!rn) begin
            model_clear();
        end else begin
            if (be != 0 && !inr) mrange = 1;
`ifdef DM_BYTEEN_CHECK_EN
            if (be != 0 && !be_legal(be)) mmis = 1;
`endif
            if (popm) mcnt--;
            if (acc) begin
                mmem[a[31:2]] = w;
                // popm already removed the head, so "full" here means no room left
                if (mcnt == LOG_DEPTH) begin
                    if (mdrop != 16'hFFFF) mdrop++;
                end else begin
                    sb.push_back('{pc: pc, addr: {a[31:2], 2'b00}, data: w});
                    mcnt++;
                end
            end
        end
    endtask

    // Monitor: compares every accepted log head against the expected order
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("log_valid", {31'h0, log_valid}, {31'h0, mcnt != 0});
            if (log_valid && log_ready) begin
                if (sb.size() == 0) begin
                    chk("log_unexpected", 32'h1, 32'h0);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("log_pc", log_pc, e.pc);
                    chk("log_addr", log_addr, e.addr);
                    chk("log_data", log_data, e.data);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          k;
        n_chk = 0; n_pass = 0;
        model_clear();
        reset = 1'b0; m_data_addr = 0; m_data_wdata = 0; m_data_byteen = 0;
        m_inst_addr = 0; log_ready = 0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Full-word store, then pop it
        step(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h3000, 0);
        step(1, 32'h10, 0, 0, 0, 1);
        chk("t1_word", m_data_rdata, 32'hDEADBEEF);
        step(1, 32'h10, 0, 0, 0, 1);
        chk("t1_valid_gone", {31'h0, log_valid}, 32'h0);

        // Single byte lane merge
        step(1, 32'h12, 32'h00AA00AA, 4'b0100, 32'h3004, 0);
        step(1, 32'h10, 0, 0, 0, 1);
        chk("t2_word", m_data_rdata, 32'hDEAABEEF);
        step(1, 32'h10, 0, 0, 0, 1);

        // Overflow: LOG_DEPTH+3 stores with the sink stalled
        for (int i = 0; i < LOG_DEPTH + 3; i++)
            step(1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 32'h4000 + 32'(4 * i), 0);
        step(1, 32'h108, 0, 0, 0, 0);
        chk("t3_dropped", {16'h0, log_dropped}, 32'd3);

        // Full FIFO: store and pop together must not drop
        step(1, 32'h200, 32'hCAFEF00D, 4'hF, 32'h5000, 1);
        step(1, 32'h200, 0, 0, 0, 0);
        chk("t4_dropped", {16'h0, log_dropped}, 32'd3);
        chk("t4_word", m_data_rdata, 32'hCAFEF00D);
        k = 0;
        while (sb.size() > 0 && k < 40) begin step(1, 0, 0, 0, 0, 1); k++; end
        chk("t4_drained", 32'(sb.size()), 32'h0);

        // Out-of-range store, then reset in the middle of a drain
        step(1, 32'h3000, 32'h12345678, 4'hF, 32'h6000, 0);
        step(1, 32'h3000, 0, 0, 0, 0);
        chk("t5_range", {31'h0, range_err}, 32'h1);
        chk("t5_rdata_oor", m_data_rdata, 32'h0);
        step(1, 32'h14, 32'h1, 4'hF, 32'h6004, 0);
        step(1, 32'h18, 32'h2, 4'hF, 32'h6008, 1);
        step(0, 32'h10, 32'h3, 4'hF, 32'h600C, 1);
        step(1, 32'h10, 0, 0, 0, 0);
        chk("t5_rdata_reset", m_data_rdata, 32'h0);
        chk("t5_valid_reset", {31'h0, log_valid}, 32'h0);

        // Non-contiguous byteen
        step(1, 32'h20, 32'h11223344, 4'b0110, 32'h7000, 0);
        step(1, 32'h20, 0, 0, 0, 1);
`ifdef DM_BYTEEN_CHECK_EN
        chk("t6_word", m_data_rdata, 32'h0);
`else
        chk("t6_word", m_data_rdata, 32'h00223300);
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            k = $urandom_range(0, 99);
            if (k < 85)      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            else if (k < 92) a = 32'h2FFC;
            else             a = 32'h3000 + 32'($urandom_range(0, 1023));
            step(($urandom_range(0, 199) != 0), a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom, 1'($urandom_range(0, 1)));
        end

        k = 0;
        while (sb.size() > 0 && k < 40) begin step(1, 0, 0, 0, 0, 1); k++; end
        chk("final_drained", 32'(sb.size()), 32'h0);
        step(1, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
